// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter and anything that drives it.
//   meas_state_t  : meter FSM encoding (WAIT_FIRST / MEASURE / TIMED_OUT)
//   DEF_CNT_W     : default counter / result width
//   DEF_TIMEOUT   : default loss-of-signal limit in clk1 cycles
//   DIV_TERMINAL  : terminal count of the companion clock divider
//   div_period()  : rise-to-rise period, in input cycles, of a divider with a given terminal count
package clk_meas_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    TIMED_OUT  = 2'd2
  } meas_state_t;

  localparam int DEF_CNT_W    = 32;
  localparam int DEF_TIMEOUT  = 200000;
  localparam int DIV_TERMINAL = 50000 - 1;

  // The divider toggles its output every (terminal+1) input cycles, so one
  // full output period spans two of those half periods.
  function automatic int div_period(input int terminal);
    return 2 * (terminal + 1);
  endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// Measurement-side bus of the clock period meter.
//   edge_tick  : one-cycle pulse per detected rising edge
//   period     : last rise-to-rise interval (clk1 cycles)
//   high_time  : last rise-to-fall interval (clk1 cycles)
//   meas_valid : period/high_time hold an unconsumed measurement
//   meas_ack   : consumer acknowledge
//   timeout    : no rising edge within the timeout window
//   overrun    : sticky, a measurement was overwritten before it was acked
// modport master : the meter; modport slave : the consumer.
interface clk_period_meter_if #(
  parameter int CNT_W = 32
);
  logic             edge_tick;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             meas_ack;
  logic             timeout;
  logic             overrun;

  modport master (
    output edge_tick, period, high_time, meas_valid, timeout, overrun,
    input  meas_ack
  );

  modport slave (
    input  edge_tick, period, high_time, meas_valid, timeout, overrun,
    output meas_ack
  );
endinterface

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Resynchronises an asynchronous level into clk1 and detects its edges.
//   clk1     : sampling clock
//   rst      : asynchronous active-high reset
//   async_in : asynchronous input level
//   level    : synchronised level (last synchroniser stage)
//   rise     : level went 0->1 this cycle (combinational from flops)
//   fall     : level went 1->0 this cycle (combinational from flops)
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk1,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk1
// cycles and publishes each result on a valid/ack handshake.
//   clk1   : system clock, all logic on its rising edge
//   rst    : asynchronous active-high reset
//   sig_in : slow signal to measure, asynchronous to clk1
//   mif    : measurement bus (master side), see clk_period_meter_if
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   sig_in,
  clk_period_meter_if.master     mif
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic sig_level;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk1     (clk1),
    .rst      (rst),
    .async_in (sig_in),
    .level    (sig_level),
    .rise     (rise),
    .fall     (fall)
  );

  // Only the edges matter here; the level output is kept for other users
  // of the synchroniser.
  logic unused_level;
  assign unused_level = sig_level;

  meas_state_t      state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] hi_cap_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             tick_q;
  logic             valid_q;
  logic             timeout_q;
  logic             overrun_q;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_FIRST;
      count_q   <= '0;
      hi_cap_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tick_q <= rise;

      // Consumption; a measurement published below in the same cycle
      // overrides this clear.
      if (mif.meas_ack && valid_q) valid_q <= 1'b0;

      unique case (state_q)
        WAIT_FIRST: begin
          count_q <= '0;
          if (rise) begin
            state_q  <= MEASURE;
            hi_cap_q <= '0;
          end
        end

        MEASURE: begin
          if (rise) begin
            // count lags the elapsed cycles by one, hence the +1.
            period_q <= count_q + CNT_W'(1);
            high_q   <= hi_cap_q;
            valid_q  <= 1'b1;
            if (valid_q && !mif.meas_ack) overrun_q <= 1'b1;
            count_q  <= '0;
          end else begin
            if (fall) hi_cap_q <= count_q + CNT_W'(1);
            if (count_q == TO_LAST) begin
              state_q   <= TIMED_OUT;
              timeout_q <= 1'b1;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end

        TIMED_OUT: begin
          // The first rise after a loss of signal is only a new reference.
          if (rise) begin
            state_q   <= MEASURE;
            timeout_q <= 1'b0;
            count_q   <= '0;
            hi_cap_q  <= '0;
          end
        end

        default: state_q <= WAIT_FIRST;
      endcase
    end
  end

  assign mif.edge_tick  = tick_q;
  assign mif.period     = period_q;
  assign mif.high_time  = high_q;
  assign mif.meas_valid = valid_q;
  assign mif.timeout    = timeout_q;
  assign mif.overrun    = overrun_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: directed scenarios with literal
// expectations plus randomized square waves and acks, all compared every
// cycle against an edge-timestamp model of the meter.
module tb_clk_period_meter;
  import clk_meas_pkg::*;

  localparam int CW = 32;
  localparam int TO = 50;
  localparam int SS = 2;
  localparam int DIV_TC = 20;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic sig_in = 1'b0;
  bit   rand_ack = 1'b0;

  clk_period_meter_if #(.CNT_W(CW)) mif ();

  clk_period_meter #(
    .CNT_W       (CW),
    .TIMEOUT     (TO),
    .SYNC_STAGES (SS)
  ) dut (
    .clk1   (clk1),
    .rst    (rst),
    .sig_in (sig_in),
    .mif    (mif)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Timestamps rising/falling edges of the synchronised input and derives
  // outputs from edge-time differences.
  bit h [0:SS+1];
  int m_idx, m_ref, m_fall;
  bit m_have_ref, m_tmo, m_fall_seen;
  int m_period, m_high;
  bit m_valid, m_over, m_tick;

  initial begin
    m_idx = 0; m_ref = 0; m_fall = 0;
    m_have_ref = 0; m_tmo = 0; m_fall_seen = 0;
    m_period = 0; m_high = 0; m_valid = 0; m_over = 0; m_tick = 0;
    forever begin
      @(posedge clk1 or posedge rst);
      if (rst) begin
        for (int i = 0; i <= SS + 1; i++) h[i] = 1'b0;
        m_have_ref = 0; m_tmo = 0; m_fall_seen = 0;
        m_period = 0; m_high = 0; m_valid = 0; m_over = 0; m_tick = 0;
      end else begin
        bit s, sp, r, f, ack_now;
        for (int i = SS + 1; i > 0; i--) h[i] = h[i-1];
        h[0] = sig_in;
        s  = h[SS];
        sp = h[SS+1];
        r  = s && !sp;
        f  = !s && sp;
        ack_now = mif.meas_ack;
        m_idx++;
        m_tick = r;
        if (r) begin
          if (m_have_ref && !m_tmo) begin
            if (m_valid && !ack_now) m_over = 1;
            m_period = m_idx - m_ref;
            m_high   = m_fall_seen ? (m_fall - m_ref) : 0;
            m_valid  = 1;
          end else if (ack_now) begin
            m_valid = 0;
          end
          m_have_ref = 1; m_tmo = 0; m_ref = m_idx; m_fall_seen = 0;
        end else begin
          if (ack_now) m_valid = 0;
          if (m_have_ref && !m_tmo) begin
            if (f) begin m_fall_seen = 1; m_fall = m_idx; end
            if (m_idx - m_ref == TO) m_tmo = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk1);
      if (!rst) begin
        check("edge_tick",  mif.edge_tick,  m_tick);
        check("period",     mif.period,     m_period);
        check("high_time",  mif.high_time,  m_high);
        check("meas_valid", mif.meas_valid, m_valid);
        check("timeout",    mif.timeout,    m_tmo);
        check("overrun",    mif.overrun,    m_over);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_level(input logic v, input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
      sig_in = v;
      if (rand_ack) mif.meas_ack = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic square(input int hi, input int lo);
    drive_level(1'b1, hi);
    drive_level(1'b0, lo);
  endtask

  initial begin
    int n;
    mif.meas_ack = 1'b0;

    // Reset state
    #12;
    check("rst_period",  mif.period, 0);
    check("rst_high",    mif.high_time, 0);
    check("rst_valid",   mif.meas_valid, 0);
    check("rst_timeout", mif.timeout, 0);
    check("rst_overrun", mif.overrun, 0);
    check("rst_tick",    mif.edge_tick, 0);
    @(posedge clk1); #1 rst = 1'b0;
    drive_level(1'b0, 3);

    // First rise: edge_tick after SYNC_STAGES+1 edges, nothing published
    @(posedge clk1); #1 sig_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk1); #1;
      check("first_tick_latency", mif.edge_tick, (i == 3));
    end
    check("first_no_valid", mif.meas_valid, 0);

    // 10 high / 10 low with ack held
    mif.meas_ack = 1'b1;
    drive_level(1'b1, 7);
    drive_level(1'b0, 10);
    repeat (3) square(10, 10);
    check("sq_period",  mif.period, 20);
    check("sq_high",    mif.high_time, 10);
    check("sq_overrun", mif.overrun, 0);

    // Handshake: unacked, coincident ack, overwrite
    mif.meas_ack = 1'b0;
    square(6, 6);
    @(posedge clk1); #1 sig_in = 1'b1;
    @(posedge clk1);
    @(posedge clk1); #1 mif.meas_ack = 1'b1;
    @(posedge clk1); #1 mif.meas_ack = 1'b0;
    drive_level(1'b0, 4);
    @(negedge clk1);
    check("coinc_valid",   mif.meas_valid, 1);
    check("coinc_overrun", mif.overrun, 0);
    check("coinc_period",  mif.period, 12);
    check("coinc_high",    mif.high_time, 6);
    square(5, 5);
    @(negedge clk1);
    check("ovr_valid",   mif.meas_valid, 1);
    check("ovr_overrun", mif.overrun, 1);
    check("ovr_period",  mif.period, 8);
    check("ovr_high",    mif.high_time, 4);
    @(posedge clk1); #1 mif.meas_ack = 1'b1;
    @(posedge clk1); #1 mif.meas_ack = 1'b0;
    @(negedge clk1);
    check("ack_clears_valid", mif.meas_valid, 0);
    check("overrun_sticky",   mif.overrun, 1);

    // Timeout
    mif.meas_ack = 1'b1;
    @(posedge clk1); #1 sig_in = 1'b1;
    n = 0;
    do begin @(negedge clk1); n++; end while (!mif.edge_tick && n < 10);
    check("tmo_tick_seen", mif.edge_tick, 1);
    n = 0;
    while (!mif.timeout && n < 200) begin
      @(negedge clk1);
      n++;
      if (n == 3) sig_in = 1'b0;
      if (n == 10) mif.meas_ack = 1'b0;
    end
    check("timeout_latency", n, TO);
    check("tmo_no_valid", mif.meas_valid, 0);
    square(3, 3);
    check("tmo_cleared", mif.timeout, 0);
    check("tmo_ref_only", mif.meas_valid, 0);
    square(7, 7);
    check("post_tmo_period", mif.period, 6);
    check("post_tmo_high",   mif.high_time, 3);
    check("post_tmo_valid",  mif.meas_valid, 1);

    // Divider-shaped input (scaled terminal count so it fits the window)
    mif.meas_ack = 1'b1;
    repeat (3) square(DIV_TC + 1, DIV_TC + 1);
    check("div_period",  mif.period, div_period(DIV_TC));
    check("div_high",    mif.high_time, DIV_TC + 1);
    check("div_timeout", mif.timeout, 0);

    // Randomized waves and acks
    rand_ack = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int hi, lo;
      hi = $urandom_range(1, 30);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 30);
      square(hi, lo);
    end
    rand_ack = 1'b0;

    // Async reset mid-measurement
    mif.meas_ack = 1'b0;
    square(5, 5);
    square(5, 5);
    drive_level(1'b0, 2);
    check("pre_rst_valid", mif.meas_valid, 1);
    @(negedge clk1); #2 rst = 1'b1;
    #1;
    check("arst_period",  mif.period, 0);
    check("arst_high",    mif.high_time, 0);
    check("arst_valid",   mif.meas_valid, 0);
    check("arst_timeout", mif.timeout, 0);
    check("arst_overrun", mif.overrun, 0);
    check("arst_tick",    mif.edge_tick, 0);
    @(posedge clk1); #1 rst = 1'b0;
    square(5, 5);
    drive_level(1'b0, 4);
    check("after_rst_first_rise", mif.meas_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
